// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester front end for a single-port synchronous RAM (registered address,
// unregistered q, one-cycle read latency).
//
// Pipeline:
//   accept edge -> S1 (RAM address/data/wren/rden registers)
//               -> S2 (tag: valid, is_read, owner; ram_q valid this cycle)
//               -> S3 (ram_q captured into rsp<owner>_rdata, one-cycle rsp<owner>_valid)
// A read is accepted on edge E0, the RAM latches its address on E0+1 and the
// data is captured on E0+2, so rsp<owner>_valid is high in the cycle after the
// third edge counted from (and including) the acceptance edge.
//
// Handshake: an access transfers on a rising edge where reqN_valid && reqN_ready.
// reqN_ready is combinational from the valids, hold, sclr0 and last_grant, and
// already includes reqN_valid, so at most one ready is high. There is no
// response backpressure: rspN_valid is a single-cycle pulse.
//
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN
//   defined   : on contention, the requester that did not win last is granted.
//   undefined : on contention, requester 0 always wins.
// last_grant is maintained in both builds and exposed on dbg_last_grant.

module ram_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clock0,
  input  logic              sclr0,
  input  logic              hold,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,

  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,

  output logic              dbg_last_grant
);

  // Owner of the most recently accepted access (reset value 1 so that the
  // first contention after reset goes to requester 0 in round-robin mode).
  logic              last_grant;

  // Contention tie-break: 1 selects requester 0 when both are valid.
  logic              pick0;

  // Accepted access, muxed from the winning requester.
  logic              accept;
  logic              acc_owner;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // S1 owner travels alongside the RAM registers.
  logic              s1_owner;

  // S2 tag: describes the access whose read data is on ram_q this cycle.
  logic              tag_valid;
  logic              tag_read;
  logic              tag_owner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Round-robin: requester 0 wins a tie only if requester 1 won last.
  assign pick0 = last_grant;
`else
  // Fixed priority: requester 0 always wins a tie.
  assign pick0 = 1'b1;
`endif

  // Grant decision: nothing is granted during reset or hold.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!sclr0 && !hold) begin
      if (req0_valid && req1_valid) begin
        req0_ready = pick0;
        req1_ready = ~pick0;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Select the fields of the granted requester.
  always_comb begin
    accept    = req0_ready | req1_ready;
    acc_owner = req1_ready;
    acc_we    = req0_we;
    acc_addr  = req0_addr;
    acc_wdata = req0_wdata;
    if (req1_ready) begin
      acc_we    = req1_we;
      acc_addr  = req1_addr;
      acc_wdata = req1_wdata;
    end
  end

  // Track the owner of every accepted access.
  always_ff @(posedge clock0) begin
    if (sclr0) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= acc_owner;
    end
  end

  assign dbg_last_grant = last_grant;

  // S1: drive the RAM port from registers; address/data hold when idle.
  always_ff @(posedge clock0) begin
    if (sclr0) begin
      ram_wren    <= 1'b0;
      ram_rden    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      s1_owner    <= 1'b0;
    end else begin
      ram_wren <= accept & acc_we;
      ram_rden <= accept & ~acc_we;
      if (accept) begin
        ram_address <= acc_addr;
        ram_data    <= acc_wdata;
        s1_owner    <= acc_owner;
      end
    end
  end

  // S2: tag follows S1 by one cycle, aligned with valid ram_q.
  always_ff @(posedge clock0) begin
    if (sclr0) begin
      tag_valid <= 1'b0;
      tag_read  <= 1'b0;
      tag_owner <= 1'b0;
    end else begin
      tag_valid <= ram_wren | ram_rden;
      tag_read  <= ram_rden;
      tag_owner <= s1_owner;
    end
  end

  // S3: capture read data for the owning requester and pulse its valid.
  always_ff @(posedge clock0) begin
    if (sclr0) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= tag_valid & tag_read & ~tag_owner;
      rsp1_valid <= tag_valid & tag_read & tag_owner;
      if (tag_valid && tag_read && !tag_owner) begin
        rsp0_rdata <= ram_q;
      end
      if (tag_valid && tag_read && tag_owner) begin
        rsp1_rdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed scenarios with literal expectations, then randomized traffic checked
// every cycle against a transaction-level model (reference memory updated in
// acceptance order plus a queue of pending read results with due cycles).
// Build with RAM_ARB_ROUND_ROBIN_EN defined to exercise round-robin arbitration.

module tb_ram_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sclr0 = 1'b1;
  logic          hold = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren, ram_rden;
  logic          dbg_last_grant;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock0(clk), .sclr0(sclr0), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q),
    .dbg_last_grant(dbg_last_grant)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i) ^ 8'hA5;
  endfunction

  // ---------------- RAM: registered address, unregistered q ----------------
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_aq = '0;
  initial for (int i = 0; i < (1 << AW); i++) ram_mem[i] = init_word(i);
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_aq <= ram_address;
  end
  assign ram_q = ram_mem[ram_aq];

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);

  logic [DW-1:0] exp_q[$];   // pending read data
  int            due_q[$];   // edge index after which the response is visible
  logic          own_q[$];   // requester that issued the read

  int            cyc = 0;
  logic          m_init = 1'b0;
  logic          m_last = 1'b1;
  logic          e_wren = 1'b0, e_rden = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic          e_v0 = 1'b0, e_v1 = 1'b0;
  logic [DW-1:0] e_rd0 = '0, e_rd1 = '0;

  // Arbitration rule from the requester's point of view.
  function automatic void exp_grant(input logic v0, input logic v1, input logic h,
                                    input logic r, input logic last,
                                    output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!r && !h) begin
      if (v0 && v1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        // the one that did not win last time gets it
        g0 = (last == 1'b1);
        g1 = (last == 1'b0);
`else
        g0 = 1'b1;
`endif
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
  endfunction

  // Model advance at each rising edge using the inputs presented before it.
  always @(posedge clk) begin
    logic g0, g1, own, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cyc++;
    exp_grant(req0_valid, req1_valid, hold, sclr0, m_last, g0, g1);
    if (sclr0) begin
      m_init = 1'b1;
      m_last = 1'b1;
      exp_q.delete(); due_q.delete(); own_q.delete();
      e_wren = 1'b0; e_rden = 1'b0; e_addr = '0; e_data = '0;
      e_v0 = 1'b0; e_v1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      e_v0 = 1'b0;
      e_v1 = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (own_q[0]) begin e_v1 = 1'b1; e_rd1 = exp_q[0]; end
        else          begin e_v0 = 1'b1; e_rd0 = exp_q[0]; end
        void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(own_q.pop_front());
      end
      if (g0 || g1) begin
        own = g1;
        we  = g1 ? req1_we : req0_we;
        a   = g1 ? req1_addr : req0_addr;
        d   = g1 ? req1_wdata : req0_wdata;
        m_last = own;
        e_wren = we;
        e_rden = !we;
        e_addr = a;
        e_data = d;
        if (we) ref_mem[a] = d;
        else begin
          exp_q.push_back(ref_mem[a]);
          due_q.push_back(cyc + 2);
          own_q.push_back(own);
        end
      end else begin
        e_wren = 1'b0;
        e_rden = 1'b0;
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    logic g0, g1;
    if (m_init) begin
      exp_grant(req0_valid, req1_valid, hold, sclr0, m_last, g0, g1);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("ram_wren", ram_wren, e_wren);
      chk("ram_rden", ram_rden, e_rden);
      chk("ram_address", ram_address, e_addr);
      chk("ram_data", ram_data, e_data);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("rsp0_rdata", rsp0_rdata, e_rd0);
      chk("rsp1_rdata", rsp1_rdata, e_rd1);
      chk("last_grant", dbg_last_grant, m_last);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drive0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic do_reset();
    idle();
    hold = 1'b0;
    sclr0 = 1'b1;
    tick();
    tick();
    sclr0 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] seq3 [4];
    int exp_g [4];
    seq3 = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    repeat (3) tick();
    sclr0 = 1'b0;
    @(negedge clk);
    chk("rst_wren", ram_wren, 0);
    chk("rst_address", ram_address, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_last_grant", dbg_last_grant, 1);

    // write 0x5A to 0x010, then read it back on the next cycle
    tick();
    drive0(1'b1, 11'h010, 8'h5A);
    @(negedge clk);
    chk("wr_ready", req0_ready, 1);
    tick();
    drive0(1'b0, 11'h010, 8'h00);
    @(negedge clk);
    chk("wr_s1_wren", ram_wren, 1);
    chk("wr_s1_addr", ram_address, 11'h010);
    chk("wr_s1_data", ram_data, 8'h5A);
    tick();
    idle();
    @(negedge clk);
    chk("rd_s1_rden", ram_rden, 1);
    chk("rd_s1_wren", ram_wren, 0);
    tick();
    @(negedge clk);
    chk("rd_early_valid", rsp0_valid, 0);
    tick();
    @(negedge clk);
    chk("raw_valid", rsp0_valid, 1);
    chk("raw_rdata", rsp0_rdata, 8'h5A);
    tick();
    @(negedge clk);
    chk("raw_pulse_end", rsp0_valid, 0);
    chk("raw_rdata_held", rsp0_rdata, 8'h5A);

    // contention for four cycles straight after reset
    do_reset();
    drive0(1'b0, 11'h020, 8'h00);
    drive1(1'b0, 11'h030, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("contend_one_hot", req0_ready + req1_ready, 1);
      chk("contend_owner", req1_ready, exp_g[k]);
      tick();
    end
    idle();
    repeat (4) tick();

    // back-to-back reads from requester 1
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive1(1'b0, AW'(c), 8'h00);
      else idle();
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk("b2b_valid", rsp1_valid, 1);
        chk("b2b_rdata", rsp1_rdata, seq3[c-3]);
      end else begin
        chk("b2b_gap", rsp1_valid, 0);
      end
      tick();
    end

    // hold while both are valid; the access accepted just before still returns
    drive0(1'b0, 11'h005, 8'h00);
    tick();
    hold = 1'b1;
    drive0(1'b0, 11'h006, 8'h00);
    drive1(1'b0, 11'h007, 8'h00);
    @(negedge clk);
    chk("hold_ready0", req0_ready, 0);
    chk("hold_ready1", req1_ready, 0);
    tick();
    @(negedge clk);
    chk("hold_ready0_b", req0_ready, 0);
    tick();
    @(negedge clk);
    chk("hold_rsp_valid", rsp0_valid, 1);
    chk("hold_rsp_rdata", rsp0_rdata, 8'hA0);
    hold = 1'b0;
    idle();
    tick();

    // reset one cycle after a read is accepted
    drive0(1'b0, 11'h006, 8'h00);
    tick();
    idle();
    sclr0 = 1'b1;
    tick();
    sclr0 = 1'b0;
    drive0(1'b0, 11'h008, 8'h00);
    drive1(1'b0, 11'h009, 8'h00);
    @(negedge clk);
    chk("mid_rst_rsp0", rsp0_valid, 0);
    chk("mid_rst_rdata0", rsp0_rdata, 0);
    chk("mid_rst_rden", ram_rden, 0);
    chk("mid_rst_addr", ram_address, 0);
    chk("post_rst_grant0", req0_ready, 1);
    chk("post_rst_grant1", req1_ready, 0);
    tick();
    idle();
    @(negedge clk);
    chk("mid_rst_no_rsp0", rsp0_valid, 0);
    chk("mid_rst_no_rsp1", rsp1_valid, 0);
    repeat (4) tick();

    // randomized traffic on a small address window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_we    = $urandom_range(0, 1) == 1;
      req0_addr  = AW'($urandom_range(0, 15));
      req0_wdata = DW'($urandom_range(0, 255));
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_we    = $urandom_range(0, 1) == 1;
      req1_addr  = AW'($urandom_range(0, 15));
      req1_wdata = DW'($urandom_range(0, 255));
      hold       = ($urandom_range(0, 15) == 0);
      sclr0      = ($urandom_range(0, 99) == 0);
      tick();
    end
    sclr0 = 1'b0;
    hold = 1'b0;
    idle();
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
